if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage: owns the program counter, drives the instruction ROM's chip-enable and byte address, and registers each returned word, tagged with its PC, toward decode. The ROM returns data combinationally in the same cycle as its address. Decode consumes words through a valid/ready handshake. A branch redirect from decode flushes everything in flight and restarts fetch at the target.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; must be word-aligned.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rom_ce` out 1: instruction ROM chip-enable; registered.
- `rom_addr` out 32: byte address to the ROM; equals the current PC.
- `rom_inst` in 32: ROM data for `rom_addr`; valid in the same cycle.
- `br_flag` in 1: redirect request from decode.
- `br_target` in 32: redirect byte address.
- `addr_err` out 1: one-cycle pulse when a misaligned `br_target` was accepted.
- `id_valid` out 1: an instruction is presented to decode.
- `id_ready` in 1: decode accepts the presented instruction this cycle.
- `id_inst` out 32: presented instruction word.
- `id_pc` out 32: byte address of `id_inst`.

## Operation
- Reset values:
  - pc = RESET_PC
  - `rom_ce` = 0
  - `id_valid` = 0
  - `id_inst` = 0
  - `id_pc` = 0
  - `addr_err` = 0
  - queue empty
- `rom_ce` becomes 1 on the first rising edge after `rst` deasserts and stays 1 until the next reset.
- Fetched words go into an internal queue, depth D (see Configuration). The queue head drives `id_valid`, `id_inst` and `id_pc`.
- Handshake: a transfer happens on an edge where `id_valid` && `id_ready`. The head pops at that edge.
  - `id_inst` and `id_pc` hold stable while `id_valid` && !`id_ready`.
- Fetch enable `fe` = `rom_ce` && (slot free at this edge):
  - D=1: slot free = !`id_valid` || `id_ready`.
  - D=2: slot free = count < 2, from registered state only.
- On an edge with `fe` and no `br_flag`:
  - push {pc, `rom_inst`} into the queue;
  - pc <= pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Without `fe`, pc holds.
- Push and pop on the same edge are allowed; count is unchanged.
- Redirect has priority over every other event on that edge. An edge with `br_flag`=1:
  - pc <= {`br_target`[31:2], 2'b00};
  - queue cleared, so `id_valid` = 0 next cycle;
  - the word currently on `rom_inst` is discarded;
  - any simultaneous handshake still counts as consumed by decode, then is flushed.
- `addr_err` pulses in the cycle after a redirect edge where `br_target`[1:0] != 0. It is 0 otherwise.
- `br_flag` while `rom_ce`=0 (first cycle after reset): pc is still loaded; the first fetch uses the target.
- Reset asserted mid-operation:
  - all state returns to reset values asynchronously;
  - queued words are lost;
  - fetch restarts at RESET_PC.

## Timing
- Fetch at edge N: the word appears on `id_*` after edge N, with `id_valid`=1 in cycle N+1.
- Steady state (`id_ready` held 1): one instruction per cycle, consecutive PCs, no bubbles.
- Reset release to first `id_valid`: 2 edges.
  - Edge 1: `rom_ce` rises.
  - Edge 2: fetch of RESET_PC.
- Redirect at edge N:
  - first target fetch at edge N+1;
  - target word valid in cycle N+2;
  - one bubble cycle (N+1) on `id_valid`.
- D=1: `id_ready` is combinationally coupled to the pc enable.
- D=2: no combinational path from `id_ready` to any register enable except the queue pop.

## Configuration
- Macro `IF_SKIDBUF_EN`.
- Defined: queue depth D=2 (skid buffer).
  - Fetch continues for one extra word after decode stalls.
  - The `id_ready` timing path is cut from the pc logic.
- Undefined: D=1; the output register is the only storage.
- Both builds give identical instruction order and identical redirect latency.
- Throughput with `id_ready`=1 is identical in both builds.

## Test plan
- Reset release, RESET_PC=0, `id_ready`=1, ROM word i = 32'h1000_0000+i -> `id_valid` rises in the 2nd cycle after release; `id_pc` = 0,4,8,… back-to-back; `id_inst` = 32'h1000_0000, 32'h1000_0001, ….
- `id_ready`=0 for 5 cycles mid-stream -> `id_inst`/`id_pc` held constant.
  - D=1: pc advances 0 words during the stall.
  - D=2: pc advances exactly 1 word during the stall.
  - After release, no word is duplicated or skipped.
- `br_flag`=1 with `br_target`=32'h0000_0040 while the queue is full -> one bubble, then `id_pc`=0x40, 0x44; `addr_err` stays 0.
- `br_target`=32'h0000_0043 -> `addr_err`=1 for exactly one cycle; next `id_pc`=0x40.
- RESET_PC=32'hFFFF_FFF8 -> `id_pc` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert `rst` mid-stream with `id_valid`=1 -> `id_valid`=0 and `rom_ce`=0 immediately (asynchronous); after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage owning the PC, the ROM request and a small queue toward decode.
// Build option IF_SKIDBUF_EN selects a two-entry skid queue; otherwise a single output register is used.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    input  logic        br_flag,
    input  logic [31:0] br_target,
    output logic        addr_err,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);

    logic        rom_ce_r;
    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    logic        addr_err_r;
    logic        addr_err_nxt_s;
    logic        valid_r;
    logic        valid_nxt_s;
    logic [31:0] head_inst_r;
    logic [31:0] head_inst_nxt_s;
    logic [31:0] head_pc_r;
    logic [31:0] head_pc_nxt_s;
    logic        slot_free_s;
    logic        fe_s;
    logic        push_s;
    logic        pop_s;

`ifdef IF_SKIDBUF_EN
    logic [1:0]  count_r;
    logic [1:0]  count_nxt_s;
    logic [31:0] tail_inst_r;
    logic [31:0] tail_inst_nxt_s;
    logic [31:0] tail_pc_r;
    logic [31:0] tail_pc_nxt_s;

    // Occupancy comes from registers only, so id_ready never reaches the pc enable.
    assign slot_free_s = (count_r != 2'd2);
`else
    assign slot_free_s = !valid_r || id_ready;
`endif

    assign fe_s   = rom_ce_r && slot_free_s;
    assign push_s = fe_s && !br_flag;
    assign pop_s  = valid_r && id_ready;

    // Next pc and misalignment flag; a redirect overrides sequential fetch.
    always_comb begin
        pc_nxt_s       = pc_r;
        addr_err_nxt_s = 1'b0;
        if (br_flag) begin
            pc_nxt_s       = {br_target[31:2], 2'b00};
            addr_err_nxt_s = (br_target[1:0] != 2'b00);
        end else if (push_s) begin
            pc_nxt_s = pc_r + 32'd4;
        end else begin
            pc_nxt_s = pc_r;
        end
    end

`ifdef IF_SKIDBUF_EN
    // Two-entry queue update: flush on redirect, otherwise push/pop with head-first fill.
    always_comb begin
        count_nxt_s     = count_r;
        head_inst_nxt_s = head_inst_r;
        head_pc_nxt_s   = head_pc_r;
        tail_inst_nxt_s = tail_inst_r;
        tail_pc_nxt_s   = tail_pc_r;
        if (br_flag) begin
            count_nxt_s = 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b11: begin
                    // Push needs a free slot and pop needs an entry, so exactly one is held.
                    head_inst_nxt_s = rom_inst;
                    head_pc_nxt_s   = pc_r;
                end
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_inst_nxt_s = rom_inst;
                        head_pc_nxt_s   = pc_r;
                    end else begin
                        tail_inst_nxt_s = rom_inst;
                        tail_pc_nxt_s   = pc_r;
                    end
                    count_nxt_s = count_r + 2'd1;
                end
                2'b01: begin
                    head_inst_nxt_s = tail_inst_r;
                    head_pc_nxt_s   = tail_pc_r;
                    count_nxt_s     = count_r - 2'd1;
                end
                default: begin
                    count_nxt_s = count_r;
                end
            endcase
        end
        valid_nxt_s = (count_nxt_s != 2'd0);
    end

    // Skid-entry and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r     <= 2'd0;
            tail_inst_r <= 32'd0;
            tail_pc_r   <= 32'd0;
        end else begin
            count_r     <= count_nxt_s;
            tail_inst_r <= tail_inst_nxt_s;
            tail_pc_r   <= tail_pc_nxt_s;
        end
    end
`else
    // Single output register: load on fetch, drop on consume or redirect.
    always_comb begin
        valid_nxt_s     = valid_r;
        head_inst_nxt_s = head_inst_r;
        head_pc_nxt_s   = head_pc_r;
        if (br_flag) begin
            valid_nxt_s = 1'b0;
        end else if (push_s) begin
            valid_nxt_s     = 1'b1;
            head_inst_nxt_s = rom_inst;
            head_pc_nxt_s   = pc_r;
        end else if (pop_s) begin
            valid_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = valid_r;
        end
    end
`endif

    // Core fetch state: pc, ROM enable, error pulse and the head presented to decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_ce_r    <= 1'b0;
            pc_r        <= RESET_PC;
            addr_err_r  <= 1'b0;
            valid_r     <= 1'b0;
            head_inst_r <= 32'd0;
            head_pc_r   <= 32'd0;
        end else begin
            rom_ce_r    <= 1'b1;
            pc_r        <= pc_nxt_s;
            addr_err_r  <= addr_err_nxt_s;
            valid_r     <= valid_nxt_s;
            head_inst_r <= head_inst_nxt_s;
            head_pc_r   <= head_pc_nxt_s;
        end
    end

    assign rom_ce   = rom_ce_r;
    assign rom_addr = pc_r;
    assign addr_err = addr_err_r;
    assign id_valid = valid_r;
    assign id_inst  = head_inst_r;
    assign id_pc    = head_pc_r;

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: randomized and directed stimulus for if_fetch, checked against a queue-based reference model.
module tb_if_fetch;

`ifdef IF_SKIDBUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

    logic        clk;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        br_flag;
    logic [31:0] br_target;
    logic        addr_err;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    int n_checks = 0;
    int n_pass   = 0;

    if_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
        .br_flag(br_flag), .br_target(br_target), .addr_err(addr_err),
        .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    assign rom_inst = rom_word(rom_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a fetch pointer plus a FIFO of {pc, word} toward decode.
    typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_ce;
    bit          m_err;
    bit          m_free;
    bit          m_pop;

    initial begin
        m_pc = RST_PC; m_ce = 0; m_err = 0; mq.delete();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_pc = RST_PC; m_ce = 0; m_err = 0; mq.delete();
            end else begin
                m_pop  = (mq.size() > 0) && id_ready;
                m_free = (DEPTH == 1) ? ((mq.size() == 0) || id_ready) : (mq.size() < 2);
                m_err  = br_flag && (br_target[1:0] != 2'b00);
                if (br_flag) begin
                    mq.delete();
                    m_pc = {br_target[31:2], 2'b00};
                end else begin
                    if (m_pop) void'(mq.pop_front());
                    if (m_ce && m_free) begin
                        mq.push_back({m_pc, rom_word(m_pc)});
                        m_pc = m_pc + 32'd4;
                    end
                end
                m_ce = 1;
            end
        end
    end

    // Compare DUT outputs to the model every cycle outside reset.
    initial forever begin
        @(negedge clk);
        if (rst === 1'b1) begin
            chk("rom_ce", {31'd0, rom_ce}, {31'd0, m_ce});
            chk("rom_addr", rom_addr, m_pc);
            chk("addr_err", {31'd0, addr_err}, {31'd0, m_err});
            chk("id_valid", {31'd0, id_valid}, {31'd0, mq.size() > 0});
            if (mq.size() > 0) begin
                chk("id_pc", id_pc, mq[0].pc);
                chk("id_inst", id_inst, mq[0].inst);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic rand_run(input int n);
        for (int i = 0; i < n; i++) begin
            id_ready  = ($urandom_range(0, 3) != 0);
            br_flag   = ($urandom_range(0, 19) == 0);
            br_target = $urandom();
            tick();
        end
        br_flag = 1'b0;
    endtask

    logic [31:0] addr_before;

    initial begin
        rst = 1'b0; id_ready = 1'b1; br_flag = 1'b0; br_target = 32'd0;
        tick(); tick();
        chk("rst_rom_ce", {31'd0, rom_ce}, 32'd0);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_inst", id_inst, 32'd0);
        chk("rst_pc", id_pc, 32'd0);
        chk("rst_err", {31'd0, addr_err}, 32'd0);
        chk("rst_addr", rom_addr, RST_PC);

        rst = 1'b1;
        tick();
        chk("rel1_ce", {31'd0, rom_ce}, 32'd1);
        chk("rel1_valid", {31'd0, id_valid}, 32'd0);
        tick();
        chk("first_valid", {31'd0, id_valid}, 32'd1);
        chk("first_pc", id_pc, 32'hFFFF_FFF8);
        chk("first_inst", id_inst, 32'h4FFF_FFFE);
        tick();
        chk("wrap_pc1", id_pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc2", id_pc, 32'h0000_0000);
        chk("wrap_inst2", id_inst, 32'h1000_0000);
        tick();
        chk("seq_pc", id_pc, 32'h0000_0004);

        // Stall decode for five cycles.
        addr_before = rom_addr;
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_pc", id_pc, 32'h0000_0004);
            chk("stall_inst", id_inst, 32'h1000_0001);
        end
        chk("stall_advance", rom_addr - addr_before, (DEPTH == 1) ? 32'd0 : 32'd4);
        id_ready = 1'b1;
        tick();
        chk("resume_pc1", id_pc, 32'h0000_0008);
        tick();
        chk("resume_pc2", id_pc, 32'h0000_000C);

        // Redirect while the queue is full.
        id_ready = 1'b0;
        tick(); tick();
        br_flag = 1'b1; br_target = 32'h0000_0040;
        tick();
        chk("br_bubble", {31'd0, id_valid}, 32'd0);
        chk("br_err0", {31'd0, addr_err}, 32'd0);
        br_flag = 1'b0; id_ready = 1'b1;
        tick();
        chk("br_pc1", id_pc, 32'h0000_0040);
        chk("br_inst1", id_inst, 32'h1000_0010);
        tick();
        chk("br_pc2", id_pc, 32'h0000_0044);
        chk("br_err1", {31'd0, addr_err}, 32'd0);

        // Misaligned redirect.
        br_flag = 1'b1; br_target = 32'h0000_0043;
        tick();
        chk("mis_err", {31'd0, addr_err}, 32'd1);
        chk("mis_valid", {31'd0, id_valid}, 32'd0);
        br_flag = 1'b0;
        tick();
        chk("mis_err_clr", {31'd0, addr_err}, 32'd0);
        chk("mis_pc", id_pc, 32'h0000_0040);

        rand_run(600);

        // Asynchronous reset mid-stream.
        id_ready = 1'b1; br_flag = 1'b0;
        tick(); tick(); tick(); tick();
        chk("pre_rst_valid", {31'd0, id_valid}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_valid", {31'd0, id_valid}, 32'd0);
        chk("async_ce", {31'd0, rom_ce}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("rerel_valid", {31'd0, id_valid}, 32'd0);
        tick();
        chk("rerel_pc", id_pc, 32'hFFFF_FFF8);

        rand_run(300);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
